// File: rtl/fb_writer_if.sv
// Interfaces for fb_writer: the RGB565 pixel stream it consumes and the
// single-port framebuffer write bus it drives.

interface pix_stream_if;
    logic        valid;
    logic        ready;
    logic [15:0] data;
    logic        sof;
    logic        eol;

    modport master (output valid, data, sof, eol, input ready);
    modport slave  (input valid, data, sof, eol, output ready);
endinterface

interface fb_wr_if #(
    parameter int AW = 17
);
    logic          we;
    logic [AW-1:0] addr;
    logic [15:0]   wdata;
    logic          busy;

    modport master (output we, addr, wdata, input busy);
    modport slave  (input we, addr, wdata, output busy);
endinterface

// File: rtl/fb_writer.sv
// fb_writer: turns an RGB565 pixel stream with sof/eol markers into linear
// framebuffer writes (y*WIDTH + x). Off-screen pixels are clipped, and a small
// FIFO absorbs back-pressure from the write port.
// Optional macro FB_CLEAR_EN: after reset, sweep the whole framebuffer with
// zeros before accepting any pixels.

module fb_writer #(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int FIFO_DEPTH = 16,
    parameter int AW         = 17
) (
    input  logic        clk,
    input  logic        reset,
    pix_stream_if.slave pix,
    fb_wr_if.master     fb,
    output logic        frame_done,
    output logic        overflow
);
    localparam int XW = $clog2(WIDTH + 1);
    localparam int YW = $clog2(HEIGHT + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = AW + 16;

`ifdef FB_CLEAR_EN
    localparam int TOTAL = WIDTH * HEIGHT;
    typedef enum logic [1:0] {CLEAR, WAIT_SOF, ACTIVE} state_t;
    localparam state_t RESET_STATE = CLEAR;
`else
    typedef enum logic [1:0] {WAIT_SOF, ACTIVE} state_t;
    localparam state_t RESET_STATE = WAIT_SOF;
`endif

    state_t        state, next_state;
    logic [XW-1:0] x, cur_x;
    logic [YW-1:0] y, cur_y;
    logic [AW-1:0] line_base, cur_base, line_addr;
    logic          accept, take, push, pop;
    logic          in_clear, clear_step;
    logic [AW-1:0] clear_addr;

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          fifo_full, fifo_empty;

    assign fifo_full  = (count == (PW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);

`ifdef FB_CLEAR_EN
    assign in_clear   = (state == CLEAR);
    assign clear_step = in_clear && !fb.busy;

    // Clear sweep address, advancing only on cycles where a zero word is written.
    always_ff @(posedge clk) begin
        if (reset) begin
            clear_addr <= '0;
        end else if (clear_step) begin
            clear_addr <= clear_addr + AW'(1);
        end
    end
`else
    assign in_clear   = 1'b0;
    assign clear_step = 1'b0;
    assign clear_addr = '0;
`endif

    // Coordinates used by the current beat: sof forces pixel (0,0) on that beat.
    always_comb begin
        cur_x    = x;
        cur_y    = y;
        cur_base = line_base;
        if (pix.sof) begin
            cur_x    = '0;
            cur_y    = '0;
            cur_base = '0;
        end
        line_addr = cur_base + AW'(cur_x);
    end

    // Next state, handshake and FIFO push/pop decisions.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the block infers a latch.
        next_state = state;
        pix.ready  = !reset && !fifo_full && !in_clear;
        accept     = pix.valid && pix.ready;
        take       = accept && (pix.sof || state == ACTIVE);
        push       = take && (cur_x < XW'(WIDTH)) && (cur_y < YW'(HEIGHT));
        pop        = !fifo_empty && !fb.busy;
        case (state)
`ifdef FB_CLEAR_EN
            CLEAR:    if (clear_step && clear_addr == AW'(TOTAL - 1)) next_state = WAIT_SOF;
`endif
            WAIT_SOF: if (accept && pix.sof) next_state = ACTIVE;
            default:  next_state = state;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register updates from pre-edge values.
        if (reset) state <= RESET_STATE;
        else       state <= next_state;
    end

    // Raster position: x saturates at WIDTH, y at HEIGHT; line_base tracks y*WIDTH by addition.
    always_ff @(posedge clk) begin
        if (reset) begin
            x         <= '0;
            y         <= '0;
            line_base <= '0;
        end else if (take) begin
            if (pix.eol) begin
                x <= '0;
                if (cur_y < YW'(HEIGHT)) begin
                    y         <= cur_y + YW'(1);
                    line_base <= cur_base + AW'(WIDTH);
                end else begin
                    y         <= cur_y;
                    line_base <= cur_base;
                end
            end else begin
                x         <= (cur_x < XW'(WIDTH)) ? cur_x + XW'(1) : cur_x;
                y         <= cur_y;
                line_base <= cur_base;
            end
        end
    end

    // Frame-done pulse and sticky unsynced-beat flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= take && pix.eol && (cur_y == YW'(HEIGHT - 1));
            if (accept && state == WAIT_SOF && !pix.sof) overflow <= 1'b1;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage of {address, pixel}.
    // NOTE: storage is not reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {line_addr, pix.data};
    end

    // Registered write port: the clear sweep has priority, otherwise drain the FIFO head.
    always_ff @(posedge clk) begin
        if (reset) begin
            fb.we    <= 1'b0;
            fb.addr  <= '0;
            fb.wdata <= '0;
        end else begin
            fb.we <= 1'b0;
            if (clear_step) begin
                fb.we    <= 1'b1;
                fb.addr  <= clear_addr;
                fb.wdata <= '0;
            end else if (pop) begin
                fb.we              <= 1'b1;
                {fb.addr, fb.wdata} <= mem[rd_ptr];
            end
        end
    end

endmodule
